alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (power of two, >= 8).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  the only clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port a  input  WIDTH  operand A.
REQ-006 SHALL have port b  input  WIDTH  operand B.
REQ-007 SHALL have port op  input  5  operation code, sampled with start.
REQ-008 SHALL have port start  input  1  issue op/a/b this cycle.
REQ-009 SHALL have port flush  input  1  abort any in-flight multi-cycle op.
REQ-010 SHALL have port res  output  WIDTH  registered result.
REQ-011 SHALL have port overflow  output  1  registered signed overflow flag.
REQ-012 SHALL have port zero  output  1  registered flag, high when res == 0.
REQ-013 SHALL have ports hi, lo  output  WIDTH each  HI/LO registers.
REQ-014 SHALL have port busy  output  1  multi-cycle op in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the issued op completes.

Function
REQ-016 SHALL use these op codes for single-cycle ops: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 ADDU, 6 SUB, 7 SUBU, 8 SLT (signed), 9 SLTU, 10 LUI ({b[15:0],0}), 11 SLL, 12 SRL, 13 SRA, 14 MFHI, 15 MFLO, 16 MTHI, 17 MTLO.
REQ-017 SHALL use these op codes for multi-cycle ops: 18 MULT, 19 MULTU, 20 DIV, 21 DIVU; codes 22-31 SHALL produce res = 0 with done pulsed.
REQ-018 SHALL compute shifts as a shifted by b[SHW-1:0]; SRA fills with a[WIDTH-1].
REQ-019 SHALL, for a single-cycle op accepted (start=1, busy=0), register res/overflow/zero at that edge and pulse done for the following cycle (latency 1).
REQ-020 SHALL set overflow only for ADD/SUB on signed overflow; res still holds the wrapped value; all other ops SHALL clear overflow.
REQ-021 SHALL, for MTHI/MTLO, write a into hi/lo at the accept edge; res = 0.
REQ-022 SHALL implement an FSM IDLE -> RUN -> FIX -> IDLE for multi-cycle ops; accept in IDLE moves to RUN with a WIDTH-step counter.
REQ-023 SHALL iterate one bit per cycle in RUN (shift-add multiply, restoring divide on magnitudes); after WIDTH steps it SHALL move to FIX, then apply sign correction and write hi/lo.
REQ-024 SHALL deliver multi-cycle results with hi/lo updated and done high exactly WIDTH+2 edges after the accept edge (34 for WIDTH=32).
REQ-025 SHALL assert busy from the edge after accept until the edge at which done rises; busy and done SHALL never be high together.
REQ-026 SHALL compute MULT/MULTU as {hi,lo} = full 2*WIDTH-bit product; signed for MULT.
REQ-027 SHALL compute DIV/DIVU as lo = quotient, hi = remainder; DIV truncates toward zero and the remainder takes the dividend's sign.
REQ-028 SHALL, on divide by zero, give hi = a and lo = all ones at normal latency.
REQ-029 SHALL give DIV of most-negative by -1 as lo = most-negative, hi = 0.
REQ-030 SHALL ignore start while busy; hi, lo, res, and the in-flight op SHALL be unchanged.
REQ-031 SHALL, on flush, return to IDLE at that edge with busy low, no done pulse, and hi/lo unchanged; flush with start in the same cycle SHALL drop the start.
REQ-032 SHALL hold res/overflow/zero between ops; multi-cycle ops SHALL leave res unchanged.

Reset
REQ-033 SHALL, with rst high at an edge, clear res, hi, lo, overflow, busy, and done, set zero = 1, set the FSM to IDLE, and clear the counter.
REQ-034 SHALL treat rst as overriding start and flush; rst mid-RUN SHALL abort without a done pulse.

Verification
REQ-035 SHALL cover ADD a=0x7FFFFFFF, b=1 -> next cycle res=0x80000000, overflow=1, zero=0, done=1.
REQ-036 SHALL cover SRA a=0x80000000, b=4 -> res=0xF8000000; SUBU 5-5 -> res=0, zero=1, overflow=0.
REQ-037 SHALL cover MULT a=-3, b=5 -> done at edge 34, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high edges 1-33.
REQ-038 SHALL cover DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> hi=7, lo=0xFFFFFFFF.
REQ-039 SHALL cover MTHI a=0x1234, then MULTU flushed at edge 10 -> no done, busy low, hi=0x1234; a new start the next cycle is accepted.
REQ-040 SHALL cover rst at edge 20 of DIVU -> all outputs at reset values, no done pulse; a start during busy is ignored and the original result is delivered.

Source files
------------

// File: rtl/alu_mdu.sv
// Single-cycle ALU plus an iterative multiply/divide unit with HI/LO registers.
// Multi-cycle ops run IDLE -> RUN (one setup cycle + WIDTH steps) -> FIX.
module alu_mdu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    input  logic             start,
    input  logic             flush,
    output logic [WIDTH-1:0] res,
    output logic             overflow,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [4:0] OpAnd  = 5'd0;
    localparam logic [4:0] OpOr   = 5'd1;
    localparam logic [4:0] OpXor  = 5'd2;
    localparam logic [4:0] OpNor  = 5'd3;
    localparam logic [4:0] OpAdd  = 5'd4;
    localparam logic [4:0] OpAddu = 5'd5;
    localparam logic [4:0] OpSub  = 5'd6;
    localparam logic [4:0] OpSubu = 5'd7;
    localparam logic [4:0] OpSlt  = 5'd8;
    localparam logic [4:0] OpSltu = 5'd9;
    localparam logic [4:0] OpLui  = 5'd10;
    localparam logic [4:0] OpSll  = 5'd11;
    localparam logic [4:0] OpSrl  = 5'd12;
    localparam logic [4:0] OpSra  = 5'd13;
    localparam logic [4:0] OpMfhi = 5'd14;
    localparam logic [4:0] OpMflo = 5'd15;
    localparam logic [4:0] OpMthi = 5'd16;
    localparam logic [4:0] OpMtlo = 5'd17;
    localparam logic [4:0] OpMult = 5'd18;
    localparam logic [4:0] OpDivu = 5'd21;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;

    localparam logic [SHW:0] LastCnt = (SHW+1)'(WIDTH);

    logic [1:0]       state_q;
    logic [SHW:0]     cnt_q;
    logic             is_div_q, is_signed_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, mcand_q;
    logic [WIDTH-1:0] res_q, hi_q, lo_q;
    logic             ovf_q, zero_q, busy_q, done_q;

    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf, is_mdu;

    assign sum    = a + b;
    assign diff   = a - b;
    assign is_mdu = (op >= OpMult) && (op <= OpDivu);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OpAnd:  alu_res = a & b;
            OpOr:   alu_res = a | b;
            OpXor:  alu_res = a ^ b;
            OpNor:  alu_res = ~(a | b);
            OpAdd: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OpAddu: alu_res = sum;
            OpSub: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OpSubu: alu_res = diff;
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OpLui:  alu_res = b << 16;
            OpSll:  alu_res = a << b[SHW-1:0];
            OpSrl:  alu_res = a >> b[SHW-1:0];
            OpSra:  alu_res = $signed(a) >>> b[SHW-1:0];
            OpMfhi: alu_res = hi_q;
            OpMflo: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // Iteration runs on magnitudes; signs are reapplied in FIX.
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem, fix_hi, fix_lo;

    always_comb begin
        sign_a   = is_signed_q & opa_q[WIDTH-1];
        sign_b   = is_signed_q & opb_q[WIDTH-1];
        mag_a    = sign_a ? -opa_q : opa_q;
        mag_b    = sign_b ? -opb_q : opb_q;

        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge   = rem_sh >= {1'b0, mcand_q};
        div_diff = rem_sh[WIDTH-1:0] - mcand_q;
        if (is_div_q) begin
            step_hi = div_ge ? div_diff : rem_sh[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end

        prod = {acc_hi_q, acc_lo_q};
        if (sign_a ^ sign_b) prod = -prod;
        quo  = (sign_a ^ sign_b) ? -acc_lo_q : acc_lo_q;
        rem  = sign_a ? -acc_hi_q : acc_hi_q;
        if (!is_div_q) begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (opb_q == '0) begin
            fix_hi = opa_q;
            fix_lo = '1;
        end else begin
            fix_hi = rem;
            fix_lo = quo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            mcand_q     <= '0;
            res_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start && is_mdu) begin
                            state_q     <= StRun;
                            busy_q      <= 1'b1;
                            cnt_q       <= '0;
                            opa_q       <= a;
                            opb_q       <= b;
                            is_div_q    <= op[2];
                            is_signed_q <= ~op[0];
                        end else if (start) begin
                            res_q  <= alu_res;
                            ovf_q  <= alu_ovf;
                            zero_q <= (alu_res == '0);
                            done_q <= 1'b1;
                            if (op == OpMthi) hi_q <= a;
                            if (op == OpMtlo) lo_q <= a;
                        end
                    end
                    StRun: begin
                        if (cnt_q == '0) begin
                            acc_hi_q <= '0;
                            acc_lo_q <= mag_a;
                            mcand_q  <= mag_b;
                        end else begin
                            acc_hi_q <= step_hi;
                            acc_lo_q <= step_lo;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastCnt) state_q <= StFix;
                    end
                    StFix: begin
                        hi_q    <= fix_hi;
                        lo_q    <= fix_lo;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign res      = res_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: transaction-level reference model compared every
// cycle, directed corner cases with literal expectations, then randomized traffic.
module tb_alu_mdu;

    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] res, hi, lo;
    logic        overflow, zero, busy, done;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    alu_mdu dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .op       (op),
        .start    (start),
        .flush    (flush),
        .res      (res),
        .overflow (overflow),
        .zero     (zero),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic ref_alu(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                           inout logic [31:0] h, inout logic [31:0] l,
                           output logic [31:0] r, output logic v);
        longint sx, sy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = '0;
        v  = 1'b0;
        case (o)
            5'd0:  r = x & y;
            5'd1:  r = x | y;
            5'd2:  r = x ^ y;
            5'd3:  r = ~(x | y);
            5'd4:  begin s = sx + sy; r = s[31:0]; v = (s > SMAX) || (s < SMIN); end
            5'd5:  r = x + y;
            5'd6:  begin s = sx - sy; r = s[31:0]; v = (s > SMAX) || (s < SMIN); end
            5'd7:  r = x - y;
            5'd8:  r = (sx < sy) ? 32'd1 : 32'd0;
            5'd9:  r = (x < y) ? 32'd1 : 32'd0;
            5'd10: r = {y[15:0], 16'h0000};
            5'd11: r = x << y[4:0];
            5'd12: r = x >> y[4:0];
            5'd13: begin s = sx >>> y[4:0]; r = s[31:0]; end
            5'd14: r = h;
            5'd15: r = l;
            5'd16: h = x;
            5'd17: l = x;
            default: r = '0;
        endcase
    endtask

    task automatic ref_mdu(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] h, output logic [31:0] l);
        longint sx, sy, q, rm;
        longint unsigned ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            5'd18: begin q = sx * sy; {h, l} = q; end
            5'd19: begin p = ux * uy; {h, l} = p; end
            5'd20: begin
                if (y == 0) begin h = x; l = '1; end
                else begin q = sx / sy; rm = sx % sy; h = rm[31:0]; l = q[31:0]; end
            end
            default: begin
                if (y == 0) begin h = x; l = '1; end
                else begin p = ux / uy; q = longint'(ux % uy); h = q[31:0]; l = p[31:0]; end
            end
        endcase
    endtask

    // Reference model: expected outputs after each rising edge.
    logic [31:0] m_res, m_hi, m_lo, p_hi, p_lo;
    logic        m_ovf, m_zero, m_busy, m_done;
    int          m_left;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_res = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0; m_zero = 1'b1;
            m_busy = 1'b0; m_left = 0; m_valid = 1'b1;
        end else if (flush) begin
            m_busy = 1'b0;
            m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
            end
        end else if (start) begin
            if (op >= 5'd18 && op <= 5'd21) begin
                ref_mdu(op, a, b, p_hi, p_lo);
                m_busy = 1'b1;
                m_left = 34;
            end else begin
                ref_alu(op, a, b, m_hi, m_lo, m_res, m_ovf);
                m_zero = (m_res == 0);
                m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("res", res, m_res);
            chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
            chk("zero", {31'b0, zero}, {31'b0, m_zero});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("done", {31'b0, done}, {31'b0, m_done});
        end
    end

    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges (starting at k0) until done; at stays 0 if it never comes by edge 40.
    task automatic wait_done(input int k0, output int at, output int bn);
        at = 0;
        bn = 0;
        for (int k = k0; k <= 40 && at == 0; k++) begin
            @(negedge clk);
            if (busy) bn++;
            if (done) at = k;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int at, bn;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_res", res, 32'h0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);

        issue(5'd4, 32'h7FFF_FFFF, 32'h1);
        chk("add_res", res, 32'h8000_0000);
        chk("add_ovf", {31'b0, overflow}, 32'd1);
        chk("add_zero", {31'b0, zero}, 32'd0);
        chk("add_done", {31'b0, done}, 32'd1);

        issue(5'd13, 32'h8000_0000, 32'd4);
        chk("sra_res", res, 32'hF800_0000);
        issue(5'd7, 32'd5, 32'd5);
        chk("subu_res", res, 32'h0);
        chk("subu_zero", {31'b0, zero}, 32'd1);
        chk("subu_ovf", {31'b0, overflow}, 32'd0);

        issue(5'd18, 32'hFFFF_FFFD, 32'd5);
        wait_done(1, at, bn);
        chk("mult_done_edge", at, 32'd34);
        chk("mult_busy_edges", bn, 32'd33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        chk("mult_res_kept", res, 32'h0);

        issue(5'd20, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, at, bn);
        chk("div_done_edge", at, 32'd34);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        issue(5'd21, 32'd7, 32'd0);
        wait_done(1, at, bn);
        chk("divu0_done_edge", at, 32'd34);
        chk("divu0_hi", hi, 32'd7);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);

        issue(5'd20, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, at, bn);
        chk("divmin_lo", lo, 32'h8000_0000);
        chk("divmin_hi", hi, 32'h0);

        // MULTU flushed at edge 10, then an immediate new op.
        issue(5'd16, 32'h1234, 32'h0);
        chk("mthi_hi", hi, 32'h1234);
        issue(5'd19, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_done", {31'b0, done}, 32'd0);
        chk("flush_hi", hi, 32'h1234);
        issue(5'd21, 32'd100, 32'd7);
        wait_done(1, at, bn);
        chk("after_flush_edge", at, 32'd34);
        chk("after_flush_hi", hi, 32'd2);
        chk("after_flush_lo", lo, 32'd14);

        op = 5'd5; a = 32'd1; b = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_drop", {31'b0, done}, 32'd0);

        // Reset at edge 20 of a DIVU with an ignored start along the way.
        issue(5'd21, 32'd50, 32'd6);
        repeat (5) @(negedge clk);
        issue(5'd4, 32'd9, 32'd9);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_res", res, 32'h0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        chk("midrst_zero", {31'b0, zero}, 32'd1);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        wait_done(21, at, bn);
        chk("midrst_no_done", at, 32'd0);

        issue(5'd21, 32'd50, 32'd6);
        repeat (4) @(negedge clk);
        issue(5'd16, 32'hDEAD, 32'h0);
        wait_done(6, at, bn);
        chk("ignored_start_edge", at, 32'd34);
        chk("ignored_start_hi", hi, 32'd2);
        chk("ignored_start_lo", lo, 32'd8);

        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 1) == 1);
            op    = ($urandom_range(0, 3) == 0) ? 5'(18 + $urandom_range(0, 3))
                                                : 5'($urandom_range(0, 31));
            a     = pick();
            b     = pick();
            flush = ($urandom_range(0, 59) == 0);
            rst   = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        start = 1'b0; flush = 1'b0; rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
